multicycle_ctrl: RTL and testbench

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

---
 rtl/multicycle_ctrl_if.sv | 40 ++++
 rtl/multicycle_ctrl.sv | 163 ++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_ctrl_if.sv
// Handshake and datapath bundle for the multicycle control unit.
//   master : the controller (drives o_*, samples i_*)
//   slave  : memories and datapath around it (drives i_*, samples o_*)
// Signals:
//   o_imem_req / i_imem_ack / i_imem_rdata : instruction fetch handshake
//   o_dmem_req / o_dmem_we / i_dmem_ack    : data memory handshake
//   i_take_target / i_target               : redirect request from the datapath
//   o_pc / o_instr / o_reg_we              : PC, instruction register, regfile strobe
//   o_state / o_trap / o_retired           : status and retired-instruction count
interface multicycle_ctrl_if #(
    parameter int unsigned INST_SIZE = 32,
    parameter int unsigned DATA_SIZE = 32
);
    logic                 o_imem_req;
    logic                 i_imem_ack;
    logic [INST_SIZE-1:0] i_imem_rdata;
    logic                 o_dmem_req;
    logic                 o_dmem_we;
    logic                 i_dmem_ack;
    logic                 i_take_target;
    logic [DATA_SIZE-1:0] i_target;
    logic [DATA_SIZE-1:0] o_pc;
    logic [INST_SIZE-1:0] o_instr;
    logic                 o_reg_we;
    logic [2:0]           o_state;
    logic                 o_trap;
    logic [31:0]          o_retired;

    modport master (
        output o_imem_req, o_dmem_req, o_dmem_we, o_pc, o_instr, o_reg_we,
               o_state, o_trap, o_retired,
        input  i_imem_ack, i_imem_rdata, i_dmem_ack, i_take_target, i_target
    );

    modport slave (
        input  o_imem_req, o_dmem_req, o_dmem_we, o_pc, o_instr, o_reg_we,
               o_state, o_trap, o_retired,
        output i_imem_ack, i_imem_rdata, i_dmem_ack, i_take_target, i_target
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multicycle RISC-V style control unit: FETCH -> DECODE -> EXECUTE -> [MEM] -> [WRITEBACK].
// Ports:
//   i_clk : clock, all state updates on the rising edge
//   i_rst : synchronous active-high reset
//   bus   : multicycle_ctrl_if master (memory handshakes, redirect, PC/IR/status outputs)
module multicycle_ctrl #(
    parameter int unsigned          INST_SIZE = 32,
    parameter int unsigned          DATA_SIZE = 32,
    parameter logic [DATA_SIZE-1:0] RESET_PC  = DATA_SIZE'(32'h0000_0000)
) (
    input logic               i_clk,
    input logic               i_rst,
    multicycle_ctrl_if.master bus
);
    typedef enum logic [2:0] {
        StFetch     = 3'd0,
        StDecode    = 3'd1,
        StExecute   = 3'd2,
        StMem       = 3'd3,
        StWriteback = 3'd4,
        StTrap      = 3'd5
    } state_e;

    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpAluI   = 7'b0010011;
    localparam logic [6:0] OpAluR   = 7'b0110011;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpLui    = 7'b0110111;
    localparam logic [6:0] OpAuipc  = 7'b0010111;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpJalr   = 7'b1100111;

    state_e               state_q, state_d;
    logic [DATA_SIZE-1:0] pc_q, pc_d;
    logic [INST_SIZE-1:0] ir_q, ir_d;
    logic [31:0]          retired_q, retired_d;
    logic                 redir_q, redir_d;
    logic [DATA_SIZE-1:0] tgt_q, tgt_d;
    // Set during the cycle after a reset edge so requests stay low while reset is held.
    logic                 rst_q;

    logic [6:0]           opcode;
    logic                 is_load, is_store, is_branch, is_jal, is_jalr, op_valid;
    logic                 take_redir, tgt_misaligned;
    logic [DATA_SIZE-1:0] redir_tgt, pc_plus4;
    logic                 imem_req;

    assign opcode    = ir_q[6:0];
    assign is_load   = (opcode == OpLoad);
    assign is_store  = (opcode == OpStore);
    assign is_branch = (opcode == OpBranch);
    assign is_jal    = (opcode == OpJal);
    assign is_jalr   = (opcode == OpJalr);
    assign op_valid  = opcode inside {OpLoad, OpStore, OpAluI, OpAluR, OpBranch,
                                      OpLui, OpAuipc, OpJal, OpJalr};

    // Redirect only honoured for control-transfer instructions.
    assign take_redir     = bus.i_take_target && (is_branch || is_jal || is_jalr);
    assign redir_tgt      = is_jalr ? {bus.i_target[DATA_SIZE-1:1], 1'b0} : bus.i_target;
    assign tgt_misaligned = (redir_tgt[1:0] != 2'b00);
    assign pc_plus4       = pc_q + DATA_SIZE'(4);
    assign imem_req       = (state_q == StFetch) && !rst_q;

    // State register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= StFetch;
            pc_q      <= RESET_PC;
            ir_q      <= '0;
            retired_q <= '0;
            redir_q   <= 1'b0;
            tgt_q     <= '0;
            rst_q     <= 1'b1;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            retired_q <= retired_d;
            redir_q   <= redir_d;
            tgt_q     <= tgt_d;
            rst_q     <= 1'b0;
        end
    end

    // Next-state logic
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        retired_d = retired_q;
        redir_d   = redir_q;
        tgt_d     = tgt_q;
        case (state_q)
            StFetch: begin
                if (imem_req && bus.i_imem_ack) begin
                    ir_d    = bus.i_imem_rdata;
                    state_d = StDecode;
                end
            end
            StDecode: state_d = op_valid ? StExecute : StTrap;
            StExecute: begin
                // Jump redirects are checked and captured here so the writeback strobe
                // can stay a pure function of state.
                redir_d = take_redir;
                tgt_d   = redir_tgt;
                if (is_load || is_store) begin
                    state_d = StMem;
                end else if (take_redir && tgt_misaligned) begin
                    state_d = StTrap;
                end else if (is_branch) begin
                    pc_d      = take_redir ? redir_tgt : pc_plus4;
                    retired_d = retired_q + 32'd1;
                    state_d   = StFetch;
                end else begin
                    state_d = StWriteback;
                end
            end
            StMem: begin
                if (bus.i_dmem_ack) begin
                    if (is_store) begin
                        pc_d      = pc_plus4;
                        retired_d = retired_q + 32'd1;
                        state_d   = StFetch;
                    end else begin
                        state_d = StWriteback;
                    end
                end
            end
            StWriteback: begin
                pc_d      = redir_q ? tgt_q : pc_plus4;
                retired_d = retired_q + 32'd1;
                state_d   = StFetch;
            end
            StTrap:  state_d = StTrap;
            default: state_d = StTrap;
        endcase
    end

    // Output decode from registered state only
    always_comb begin
        bus.o_imem_req = 1'b0;
        bus.o_dmem_req = 1'b0;
        bus.o_dmem_we  = 1'b0;
        bus.o_reg_we   = 1'b0;
        bus.o_trap     = 1'b0;
        case (state_q)
            StFetch:     bus.o_imem_req = imem_req;
            StMem: begin
                bus.o_dmem_req = 1'b1;
                bus.o_dmem_we  = is_store;
            end
            StWriteback: bus.o_reg_we = (ir_q[11:7] != 5'd0);
            StTrap:      bus.o_trap = 1'b1;
            default:     bus.o_trap = 1'b0;
        endcase
    end

    assign bus.o_pc      = pc_q;
    assign bus.o_instr   = ir_q;
    assign bus.o_state   = state_q;
    assign bus.o_retired = retired_q;
endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: directed scenarios followed by random
// instruction streams compared against an instruction-level reference model.
module tb_multicycle_ctrl;
    localparam logic [31:0] ResetPc = 32'h0000_0000;
    localparam logic [2:0]  StFetch = 3'd0;
    localparam logic [2:0]  StDec   = 3'd1;
    localparam logic [2:0]  StExe   = 3'd2;
    localparam logic [2:0]  StMem   = 3'd3;
    localparam logic [2:0]  StWb    = 3'd4;
    localparam logic [2:0]  StTrap  = 3'd5;

    logic i_clk = 1'b0;
    logic i_rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    // Reference model: architectural state per retired instruction
    logic [31:0] ref_pc;
    logic [31:0] ref_retired;
    logic        ref_trap;

    logic [6:0] valid_ops [9] = '{7'b0000011, 7'b0100011, 7'b0010011, 7'b0110011, 7'b1100011,
                                  7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111};
    logic [6:0] bad_ops [3]   = '{7'b0001111, 7'b0000000, 7'b1111111};

    multicycle_ctrl_if #(.INST_SIZE(32), .DATA_SIZE(32)) bus ();

    multicycle_ctrl #(
        .INST_SIZE(32),
        .DATA_SIZE(32),
        .RESET_PC (ResetPc)
    ) dut (
        .i_clk(i_clk),
        .i_rst(i_rst),
        .bus  (bus)
    );

    always #5 i_clk = ~i_clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        ref_pc      = ResetPc;
        ref_retired = 32'd0;
        ref_trap    = 1'b0;
    endtask

    // Entered and left at a falling edge; leaves the DUT in its first FETCH cycle.
    task automatic do_reset();
        i_rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            bus.i_imem_ack   = 1'($urandom_range(0, 1));
            bus.i_dmem_ack   = 1'($urandom_range(0, 1));
            bus.i_imem_rdata = $urandom();
            @(negedge i_clk);
            check_val("rst_state", 32'(bus.o_state), 32'(StFetch));
            check_val("rst_pc", bus.o_pc, ResetPc);
            check_val("rst_instr", bus.o_instr, 32'd0);
            check_val("rst_retired", bus.o_retired, 32'd0);
            check_val("rst_trap", 32'(bus.o_trap), 32'd0);
            check_val("rst_reg_we", 32'(bus.o_reg_we), 32'd0);
            check_val("rst_imem_req", 32'(bus.o_imem_req), 32'd0);
            check_val("rst_dmem_req", 32'(bus.o_dmem_req), 32'd0);
        end
        i_rst          = 1'b0;
        bus.i_imem_ack = 1'b0;
        bus.i_dmem_ack = 1'b0;
        @(negedge i_clk);
        check_val("post_rst_imem_req", 32'(bus.o_imem_req), 32'd1);
        check_val("post_rst_pc", bus.o_pc, ResetPc);
        model_reset();
    endtask

    // Runs one instruction from its first FETCH cycle with iw fetch waits and dw data waits.
    task automatic run_instr(input logic [31:0] instr, input logic take, input logic [31:0] tgt,
                             input int iw, input int dw);
        logic [6:0]  op;
        logic [2:0]  trace[$];
        logic [2:0]  st;
        logic        is_ld, is_st, is_br, is_jmp, valid, rd_nz, redir, mis;
        logic [31:0] dest;
        int          fetch_n, mem_n;
        op     = instr[6:0];
        valid  = op inside {7'b0000011, 7'b0100011, 7'b0010011, 7'b0110011, 7'b1100011,
                            7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111};
        is_ld  = (op == 7'b0000011);
        is_st  = (op == 7'b0100011);
        is_br  = (op == 7'b1100011);
        is_jmp = (op == 7'b1101111) || (op == 7'b1100111);
        rd_nz  = (instr[11:7] != 5'd0);
        dest   = (op == 7'b1100111) ? (tgt & ~32'h1) : tgt;
        redir  = take && (is_br || is_jmp);
        mis    = redir && (dest[1:0] != 2'b00);

        for (int k = 0; k <= iw; k++) trace.push_back(StFetch);
        trace.push_back(StDec);
        if (valid) begin
            trace.push_back(StExe);
            if (is_ld || is_st) for (int k = 0; k <= dw; k++) trace.push_back(StMem);
            if (is_ld || !(is_st || is_br || (is_jmp && mis))) trace.push_back(StWb);
        end

        bus.i_take_target = take;
        bus.i_target      = tgt;
        fetch_n = 0;
        mem_n   = 0;
        foreach (trace[i]) begin
            st = trace[i];
            check_val("state", 32'(bus.o_state), 32'(st));
            check_val("imem_req", 32'(bus.o_imem_req), 32'(st == StFetch));
            check_val("dmem_req", 32'(bus.o_dmem_req), 32'(st == StMem));
            check_val("dmem_we", 32'(bus.o_dmem_we), 32'(st == StMem && is_st));
            check_val("reg_we", 32'(bus.o_reg_we), 32'(st == StWb && rd_nz));
            // Stray acks outside their own state must be ignored.
            if (st == StFetch) begin
                bus.i_imem_ack   = (fetch_n == iw);
                bus.i_imem_rdata = bus.i_imem_ack ? instr : $urandom();
                fetch_n++;
            end else begin
                bus.i_imem_ack   = 1'($urandom_range(0, 1));
                bus.i_imem_rdata = $urandom();
            end
            if (st == StMem) begin
                bus.i_dmem_ack = (mem_n == dw);
                mem_n++;
            end else begin
                bus.i_dmem_ack = 1'($urandom_range(0, 1));
            end
            @(negedge i_clk);
        end
        bus.i_imem_ack = 1'b0;
        bus.i_dmem_ack = 1'b0;

        // Misaligned jump: bounded wait for the trap, no register write on the way.
        if (is_jmp && mis) begin
            for (int k = 0; k < 3 && !bus.o_trap; k++) begin
                check_val("trap_reg_we", 32'(bus.o_reg_we), 32'd0);
                @(negedge i_clk);
            end
        end

        if (!valid || mis) begin
            ref_trap = 1'b1;
        end else begin
            ref_pc      = redir ? dest : ref_pc + 32'd4;
            ref_retired = ref_retired + 32'd1;
        end
        check_val("end_state", 32'(bus.o_state), ref_trap ? 32'(StTrap) : 32'(StFetch));
        check_val("end_pc", bus.o_pc, ref_pc);
        check_val("end_retired", bus.o_retired, ref_retired);
        check_val("end_trap", 32'(bus.o_trap), 32'(ref_trap));
        check_val("end_instr", bus.o_instr, instr);
    endtask

    initial begin
        logic [31:0] r, r2, instr, tgt;
        logic [6:0]  op;
        int          sel;
        bus.i_imem_ack    = 1'b0;
        bus.i_imem_rdata  = '0;
        bus.i_dmem_ack    = 1'b0;
        bus.i_take_target = 1'b0;
        bus.i_target      = '0;
        model_reset();
        @(negedge i_clk);
        do_reset();

        // addi x1, zero-wait, then lw with a 3-cycle data wait
        run_instr(32'h0010_0093, 1'b0, 32'h0, 0, 0);
        run_instr(32'h0000_A083, 1'b1, 32'h0000_0040, 0, 3);
        // beq taken to 0x100, then jalr to 0x203 -> 0x202 misaligned -> trap
        run_instr(32'h0000_0063, 1'b1, 32'h0000_0100, 1, 0);
        run_instr(32'h0000_00E7, 1'b1, 32'h0000_0203, 0, 0);

        // FENCE traps after decode and stays trapped through stray acks
        do_reset();
        run_instr(32'h0000_000F, 1'b0, 32'h0, 2, 0);
        for (int k = 0; k < 3; k++) begin
            bus.i_imem_ack = 1'b1;
            bus.i_dmem_ack = 1'b1;
            @(negedge i_clk);
            check_val("trap_sticky", 32'(bus.o_trap), 32'd1);
            check_val("trap_imem_req", 32'(bus.o_imem_req), 32'd0);
        end
        do_reset();

        // PC wrap: jal to 0xFFFF_FFFC, then addi retires to 0
        run_instr(32'h0000_006F, 1'b1, 32'hFFFF_FFFC, 0, 0);
        run_instr(32'h0010_0093, 1'b0, 32'h0, 0, 0);
        check_val("pc_wrap", bus.o_pc, 32'h0);

        // Reset asserted during MEM with a same-cycle data ack
        do_reset();
        bus.i_imem_ack   = 1'b1;
        bus.i_imem_rdata = 32'h0000_A083;
        @(negedge i_clk);
        bus.i_imem_ack = 1'b0;
        @(negedge i_clk);
        @(negedge i_clk);
        check_val("mid_mem_req", 32'(bus.o_dmem_req), 32'd1);
        i_rst          = 1'b1;
        bus.i_dmem_ack = 1'b1;
        @(negedge i_clk);
        check_val("mid_rst_state", 32'(bus.o_state), 32'(StFetch));
        check_val("mid_rst_reg_we", 32'(bus.o_reg_we), 32'd0);
        check_val("mid_rst_retired", bus.o_retired, 32'd0);
        i_rst          = 1'b0;
        bus.i_dmem_ack = 1'b0;
        @(negedge i_clk);
        check_val("mid_rst_fetch", 32'(bus.o_imem_req), 32'd1);
        model_reset();

        // Random instruction stream
        for (int n = 0; n < 150; n++) begin
            if (ref_trap) do_reset();
            sel = $urandom_range(0, 19);
            op  = (sel < 18) ? valid_ops[sel % 9] : bad_ops[sel - 18];
            r   = $urandom();
            r2  = $urandom();
            instr = {r[31:7], op};
            tgt   = ($urandom_range(0, 4) == 0) ? r2 : {r2[31:2], 2'b00};
            run_instr(instr, 1'($urandom_range(0, 1)), tgt,
                      $urandom_range(0, 3), $urandom_range(0, 3));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
